acquisition_sequencer: RTL and testbench

//  Run/frame sequencer between USB command path and readout_controller. Decodes 16-bit

---
 rtl/acq_pkg.sv | 28 ++
 rtl/acq_cycle_timer.sv | 38 +++
 rtl/acquisition_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_acquisition_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acq_pkg: command fields, opcodes, FSM state codes for acquisition_sequencer |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package acq_pkg;

  localparam int CMD_OP_W  = 2;
  localparam int CMD_VAL_W = 14;

  localparam logic [CMD_OP_W-1:0] CMD_NOOP       = 2'b00;
  localparam logic [CMD_OP_W-1:0] CMD_START      = 2'b01;
  localparam logic [CMD_OP_W-1:0] CMD_STOP       = 2'b10;
  localparam logic [CMD_OP_W-1:0] CMD_SET_FRAMES = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_INTEG   = 2'd1;
  localparam logic [1:0] ST_READOUT = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  localparam int INTEG_SHIFT = 2;

  function automatic logic [31:0] integ_len(input logic [CMD_VAL_W-1:0] val);
    return 32'(val) << INTEG_SHIFT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/acq_cycle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acq_cycle_timer: loadable 32-bit down-counter, expire_o flags the last cycle|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module acq_cycle_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] load_value_i,
  input  logic        enable_i,
  output logic        expire_o
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (enable_i && (count_q != 32'd0)) begin
      count_d = count_q - 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // A load of N therefore yields exactly N enabled cycles before expiry acts.
  assign expire_o = (count_q == 32'd1);

endmodule
`default_nettype wire

// File: rtl/acquisition_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | acquisition_sequencer: command decode and frame timing (integrate/readout/ |
// | gap). Optional FRAME_LIMIT_EN adds SET_FRAMES and frame_limit_hit.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module acquisition_sequencer
  import acq_pkg::*;
#(
  parameter int          GAP_CYCLES      = 16,
  parameter int          READOUT_TIMEOUT = 200000,
  parameter logic [31:0] INTEG_RESET_VAL = 32'd5000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [15:0] cmd_word,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        readout_done,
  output logic        running,
  output logic [31:0] integration_clock_count,
  output logic        start_frame,
  output logic [15:0] frame_count,
  output logic        cmd_error,
`ifdef FRAME_LIMIT_EN
  output logic        frame_limit_hit,
`endif
  output logic        timeout_error
);

  localparam logic [31:0] GAP_LOAD     = 32'(GAP_CYCLES);
  localparam logic [31:0] TIMEOUT_LOAD = 32'(READOUT_TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic        running_q, running_d;
  logic        start_frame_q, start_frame_d;
  logic        cmd_error_q, cmd_error_d;
  logic        timeout_error_q, timeout_error_d;
  logic        stop_pending_q, stop_pending_d;
  logic        cmd_ready_q;
  logic [31:0] integ_count_q, integ_count_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic                    w_accept, w_is_start, w_is_stop, w_is_rsvd;
  logic [CMD_OP_W-1:0]     w_op;
  logic [CMD_VAL_W-1:0]    w_val;
  logic [15:0]             w_frame_count_inc;
  logic                    w_limit_reached;
  logic                    w_tmr_load, w_tmr_en, w_tmr_expire;
  logic [31:0]             w_tmr_value;

`ifdef FRAME_LIMIT_EN
  logic [CMD_VAL_W-1:0] frame_limit_q, frame_limit_d;
  logic                 limit_hit_q, limit_hit_d;
`endif

  assign w_accept = cmd_valid && cmd_ready_q;
  assign w_op     = cmd_word[15:14];
  assign w_val    = cmd_word[13:0];

  always_comb begin
    w_is_start = 1'b0;
    w_is_stop  = 1'b0;
    w_is_rsvd  = 1'b0;
    if (w_accept) begin
      case (w_op)
        CMD_START:      w_is_start = 1'b1;
        CMD_STOP:       w_is_stop  = 1'b1;
        CMD_SET_FRAMES: w_is_rsvd  = 1'b1;
        CMD_NOOP:       ;
        default:        ;
      endcase
    end
  end

  assign w_frame_count_inc = (frame_count_q == 16'hFFFF) ? frame_count_q : frame_count_q + 16'd1;

`ifdef FRAME_LIMIT_EN
  assign w_limit_reached = (frame_limit_q != '0) && (w_frame_count_inc == {2'b00, frame_limit_q});
`else
  assign w_limit_reached = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    running_d       = running_q;
    start_frame_d   = 1'b0;
    cmd_error_d     = 1'b0;
    timeout_error_d = timeout_error_q;
    stop_pending_d  = stop_pending_q;
    integ_count_d   = integ_count_q;
    frame_count_d   = frame_count_q;
    w_tmr_load      = 1'b0;
    w_tmr_value     = 32'd0;
    w_tmr_en        = 1'b0;
`ifdef FRAME_LIMIT_EN
    frame_limit_d   = frame_limit_q;
    limit_hit_d     = 1'b0;
    if (w_is_rsvd) begin
      if (state_q == ST_IDLE) frame_limit_d = w_val;
      else                    cmd_error_d   = 1'b1;
    end
`else
    if (w_is_rsvd) cmd_error_d = 1'b1;
`endif

    if (w_is_start && (state_q != ST_IDLE)) cmd_error_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (w_is_start) begin
          if (w_val != '0) begin
            integ_count_d   = integ_len(w_val);
            frame_count_d   = 16'd0;
            timeout_error_d = 1'b0;
            stop_pending_d  = 1'b0;
            running_d       = 1'b1;
            state_d         = ST_INTEG;
            w_tmr_load      = 1'b1;
            w_tmr_value     = integ_len(w_val);
          end else begin
            cmd_error_d = 1'b1;
          end
        end
      end
      ST_INTEG: begin
        w_tmr_en = 1'b1;
        if (w_is_stop) begin
          running_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (w_tmr_expire) begin
          start_frame_d = 1'b1;
          state_d       = ST_READOUT;
          w_tmr_load    = 1'b1;
          w_tmr_value   = TIMEOUT_LOAD;
        end
      end
      ST_READOUT: begin
        w_tmr_en = 1'b1;
        if (w_is_stop) stop_pending_d = 1'b1;
        // Completion takes priority over a coincident timeout.
        if (readout_done) begin
          frame_count_d = w_frame_count_inc;
          if (stop_pending_q || w_is_stop || w_limit_reached) begin
            running_d      = 1'b0;
            stop_pending_d = 1'b0;
            state_d        = ST_IDLE;
`ifdef FRAME_LIMIT_EN
            limit_hit_d    = w_limit_reached;
`endif
          end else if (GAP_CYCLES == 0) begin
            state_d     = ST_INTEG;
            w_tmr_load  = 1'b1;
            w_tmr_value = integ_count_q;
          end else begin
            state_d     = ST_GAP;
            w_tmr_load  = 1'b1;
            w_tmr_value = GAP_LOAD;
          end
        end else if (w_tmr_expire) begin
          timeout_error_d = 1'b1;
          running_d       = 1'b0;
          stop_pending_d  = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      ST_GAP: begin
        w_tmr_en = 1'b1;
        if (w_is_stop) begin
          running_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (w_tmr_expire) begin
          state_d     = ST_INTEG;
          w_tmr_load  = 1'b1;
          w_tmr_value = integ_count_q;
        end
      end
      default: begin
        running_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      running_q       <= 1'b0;
      start_frame_q   <= 1'b0;
      cmd_error_q     <= 1'b0;
      timeout_error_q <= 1'b0;
      stop_pending_q  <= 1'b0;
      cmd_ready_q     <= 1'b0;
      integ_count_q   <= INTEG_RESET_VAL;
      frame_count_q   <= 16'd0;
    end else begin
      state_q         <= state_d;
      running_q       <= running_d;
      start_frame_q   <= start_frame_d;
      cmd_error_q     <= cmd_error_d;
      timeout_error_q <= timeout_error_d;
      stop_pending_q  <= stop_pending_d;
      cmd_ready_q     <= 1'b1;
      integ_count_q   <= integ_count_d;
      frame_count_q   <= frame_count_d;
    end
  end

`ifdef FRAME_LIMIT_EN
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      frame_limit_q <= '0;
      limit_hit_q   <= 1'b0;
    end else begin
      frame_limit_q <= frame_limit_d;
      limit_hit_q   <= limit_hit_d;
    end
  end

  assign frame_limit_hit = limit_hit_q;
`endif

  acq_cycle_timer u_timer (
    .clk_i        (clk_in),
    .rst_i        (reset),
    .load_i       (w_tmr_load),
    .load_value_i (w_tmr_value),
    .enable_i     (w_tmr_en),
    .expire_o     (w_tmr_expire)
  );

  assign cmd_ready               = cmd_ready_q;
  assign running                 = running_q;
  assign integration_clock_count = integ_count_q;
  assign start_frame             = start_frame_q;
  assign frame_count             = frame_count_q;
  assign cmd_error               = cmd_error_q;
  assign timeout_error           = timeout_error_q;

endmodule
`default_nettype wire

// File: tb/tb_acquisition_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_acquisition_sequencer: randomized scenario bench with timing model       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_acquisition_sequencer;

  localparam int GAP   = 16;
  localparam int TOUT  = 50;
  localparam int RSTV  = 5000;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cmd_word = 16'd0;
  logic        cmd_valid = 1'b0;
  logic        readout_done = 1'b0;
  logic        cmd_ready, running, start_frame, cmd_error, timeout_error;
  logic [31:0] integration_clock_count;
  logic [15:0] frame_count;
`ifdef FRAME_LIMIT_EN
  logic        frame_limit_hit;
`endif

  int checks = 0;
  int failures = 0;

  acquisition_sequencer #(
    .GAP_CYCLES      (GAP),
    .READOUT_TIMEOUT (TOUT),
    .INTEG_RESET_VAL (32'(RSTV))
  ) dut (
    .clk_in                  (clk_in),
    .reset                   (reset),
    .cmd_word                (cmd_word),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .readout_done            (readout_done),
    .running                 (running),
    .integration_clock_count (integration_clock_count),
    .start_frame             (start_frame),
    .frame_count             (frame_count),
    .cmd_error               (cmd_error),
`ifdef FRAME_LIMIT_EN
    .frame_limit_hit         (frame_limit_hit),
`endif
    .timeout_error           (timeout_error)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [13:0] val);
    cmd_word  = {op, val};
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_done();
    readout_done = 1'b1;
    tick();
    readout_done = 1'b0;
  endtask

  // Returns cycles until the selected output rises, or -1 if the bound expires.
  task automatic wait_sig(input int which, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if ((which == 0 && start_frame) || (which == 1 && timeout_error)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    checks++; if (integration_clock_count !== 32'(RSTV)) begin failures++; $display("FAIL reset_icc got=%0d exp=%0d", integration_clock_count, RSTV); end
    checks++; if ({start_frame, cmd_error, timeout_error, frame_count} !== 19'd0) begin failures++; $display("FAIL reset_misc got=%b/%b/%b/%0d exp=0", start_frame, cmd_error, timeout_error, frame_count); end
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL ready_before_edge got=%b exp=0", cmd_ready); end
    tick();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL ready_after_edge got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_frames(input int runs);
    int v, nfr, d, n, exp_n;
    for (int r = 0; r < runs; r++) begin
      v   = $urandom_range(1, 6);
      nfr = $urandom_range(2, 3);
      send(2'b01, 14'(v));
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL frames_running got=%b exp=1", running); end
      checks++; if (integration_clock_count !== 32'(4 * v)) begin failures++; $display("FAIL frames_icc got=%0d exp=%0d", integration_clock_count, 4 * v); end
      checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL frames_fc_clear got=%0d exp=0", frame_count); end
      for (int f = 1; f <= nfr; f++) begin
        exp_n = (f == 1) ? 4 * v : GAP + 4 * v;
        wait_sig(0, 200, n);
        checks++; if (n !== exp_n) begin failures++; $display("FAIL frames_start_lat f=%0d got=%0d exp=%0d", f, n, exp_n); end
        tick();
        checks++; if (start_frame !== 1'b0) begin failures++; $display("FAIL frames_start_pulse got=%b exp=0", start_frame); end
        d = $urandom_range(0, 20);
        if (f == nfr) send(2'b10, 14'd0);
        repeat (d) tick();
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL frames_run_readout got=%b exp=1", running); end
        pulse_done();
        checks++; if (frame_count !== 16'(f)) begin failures++; $display("FAIL frames_count got=%0d exp=%0d", frame_count, f); end
      end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL frames_stop_idle got=%b exp=0", running); end
      wait_sig(0, 40, n);
      checks++; if (n !== -1) begin failures++; $display("FAIL frames_no_restart got=%0d exp=-1", n); end
    end
  endtask

  task automatic test_stop_integ();
    int v, n;
    v = $urandom_range(3, 8);
    send(2'b01, 14'(v));
    repeat (4) tick();
    send(2'b10, 14'd0);
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL stop_integ_running got=%b exp=0", running); end
    wait_sig(0, 4 * v + 20, n);
    checks++; if (n !== -1) begin failures++; $display("FAIL stop_integ_start got=%0d exp=-1", n); end
    checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL stop_integ_fc got=%0d exp=0", frame_count); end
  endtask

  task automatic test_cmd_errors();
    int v;
    send(2'b01, 14'd0);
    checks++; if ({cmd_error, running} !== 2'b10) begin failures++; $display("FAIL err_start0 got=%b%b exp=10", cmd_error, running); end
    tick();
    checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL err_pulse_width got=%b exp=0", cmd_error); end
    send(2'b10, 14'd7);
    checks++; if ({cmd_error, running} !== 2'b00) begin failures++; $display("FAIL err_stop_idle got=%b%b exp=00", cmd_error, running); end
    send(2'b11, 14'd0);
`ifdef FRAME_LIMIT_EN
    checks++; if ({cmd_error, running} !== 2'b00) begin failures++; $display("FAIL err_op3_idle got=%b%b exp=00", cmd_error, running); end
`else
    checks++; if ({cmd_error, running} !== 2'b10) begin failures++; $display("FAIL err_op3_idle got=%b%b exp=10", cmd_error, running); end
`endif
    send(2'b00, 14'd9);
    checks++; if ({cmd_error, running} !== 2'b00) begin failures++; $display("FAIL err_noop got=%b%b exp=00", cmd_error, running); end
    v = $urandom_range(4, 9);
    send(2'b01, 14'(v));
    send(2'b01, 14'(v + 3));
    checks++; if ({cmd_error, running} !== 2'b11) begin failures++; $display("FAIL err_start_busy got=%b%b exp=11", cmd_error, running); end
    checks++; if (integration_clock_count !== 32'(4 * v)) begin failures++; $display("FAIL err_icc_kept got=%0d exp=%0d", integration_clock_count, 4 * v); end
    send(2'b11, 14'd5);
    checks++; if ({cmd_error, running} !== 2'b11) begin failures++; $display("FAIL err_op3_busy got=%b%b exp=11", cmd_error, running); end
    send(2'b10, 14'd0);
    checks++; if ({cmd_error, running} !== 2'b00) begin failures++; $display("FAIL err_cleanup got=%b%b exp=00", cmd_error, running); end
  endtask

  task automatic test_timeout();
    int v, n;
    v = $urandom_range(1, 4);
    send(2'b01, 14'(v));
    wait_sig(0, 100, n);
    wait_sig(1, 100, n);
    checks++; if (n !== TOUT) begin failures++; $display("FAIL timeout_lat got=%0d exp=%0d", n, TOUT); end
    checks++; if ({running, frame_count} !== 17'd0) begin failures++; $display("FAIL timeout_idle got=%b/%0d exp=0/0", running, frame_count); end
    pulse_done();
    checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL done_in_idle got=%0d exp=0", frame_count); end
    send(2'b01, 14'(v));
    checks++; if (timeout_error !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", timeout_error); end
    wait_sig(0, 100, n);
    repeat (TOUT - 1) tick();
    pulse_done();
    checks++; if ({frame_count, timeout_error, running} !== {16'd1, 2'b01}) begin failures++; $display("FAIL done_vs_timeout got=%0d/%b/%b exp=1/0/1", frame_count, timeout_error, running); end
    send(2'b10, 14'd0);
    checks++; if ({frame_count, running} !== {16'd1, 1'b0}) begin failures++; $display("FAIL stop_gap got=%0d/%b exp=1/0", frame_count, running); end
  endtask

  task automatic test_reset_midframe();
    int n;
    send(2'b01, 14'd5);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    checks++; if ({running, cmd_ready} !== 2'b00) begin failures++; $display("FAIL midreset_outs got=%b%b exp=00", running, cmd_ready); end
    checks++; if (integration_clock_count !== 32'(RSTV)) begin failures++; $display("FAIL midreset_icc got=%0d exp=%0d", integration_clock_count, RSTV); end
    @(negedge clk_in);
    reset = 1'b0;
    wait_sig(0, 40, n);
    checks++; if (n !== -1) begin failures++; $display("FAIL midreset_start got=%0d exp=-1", n); end
  endtask

`ifdef FRAME_LIMIT_EN
  task automatic test_frame_limit();
    int n;
    send(2'b11, 14'd2);
    send(2'b01, 14'd1);
    wait_sig(0, 100, n);
    pulse_done();
    checks++; if ({frame_limit_hit, running} !== 2'b01) begin failures++; $display("FAIL limit_first got=%b%b exp=01", frame_limit_hit, running); end
    wait_sig(0, 100, n);
    pulse_done();
    checks++; if ({frame_limit_hit, running, frame_count} !== {2'b10, 16'd2}) begin failures++; $display("FAIL limit_hit got=%b%b/%0d exp=10/2", frame_limit_hit, running, frame_count); end
    tick();
    checks++; if (frame_limit_hit !== 1'b0) begin failures++; $display("FAIL limit_pulse got=%b exp=0", frame_limit_hit); end
    send(2'b11, 14'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_frames(3);
    test_stop_integ();
    test_cmd_errors();
    test_timeout();
`ifdef FRAME_LIMIT_EN
    test_frame_limit();
`endif
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
